// File: rtl/mul32p_retire_if.sv
// Issue and result handshake bundle for mul32p_retire.
// master = issuer/consumer side, slave = the retire stage.
interface mul32p_retire_if #(
  parameter int TAG_W = 5
);
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [TAG_W-1:0] issue_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output issue_valid, issue_op, issue_tag, out_ready,
    input  issue_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  issue_valid, issue_op, issue_tag, out_ready,
    output issue_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/mul32p_retire.sv
// Retire stage behind the mul32p multiplier: latency-matched tag/valid line,
// credit-protected result FIFO. Define MUL32P_RETIRE_BYPASS_EN for the empty-FIFO bypass.
module mul32p_retire #(
  parameter int LAT   = 8,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mul32p_retire_if.slave io,
  output logic [1:0]  mul_mode,
  input  logic [31:0] mul_lo,
  input  logic [31:0] mul_hi
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic             dl_valid_reg [LAT];
  logic             dl_hi_reg    [LAT];
  logic [TAG_W-1:0] dl_tag_reg   [LAT];

  logic [31:0]      mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, inflight_reg;

  logic             accept;
  logic             tail_valid;
  logic [31:0]      tail_data;
  logic [TAG_W-1:0] tail_tag;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  always_comb begin
    case (io.issue_op)
      2'b01:   mul_mode = 2'b01;
      2'b10:   mul_mode = 2'b10;
      default: mul_mode = 2'b00;
    endcase
  end

  // Credit: every in-flight op already owns a FIFO slot, so a pop adds credit only next cycle.
  assign io.issue_ready = rst_n &
      (({1'b0, inflight_reg} + {1'b0, count_reg}) < (CW + 1)'(DEPTH));
  assign accept = io.issue_valid & io.issue_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dl_valid_reg[i] <= 1'b0;
    end else begin
      dl_valid_reg[0] <= accept;
      for (int i = 1; i < LAT; i++) dl_valid_reg[i] <= dl_valid_reg[i-1];
    end
    dl_hi_reg[0]  <= (io.issue_op != 2'b00);
    dl_tag_reg[0] <= io.issue_tag;
    for (int i = 1; i < LAT; i++) begin
      dl_hi_reg[i]  <= dl_hi_reg[i-1];
      dl_tag_reg[i] <= dl_tag_reg[i-1];
    end
  end

  assign tail_valid = dl_valid_reg[LAT-1];
  assign tail_data  = dl_hi_reg[LAT-1] ? mul_hi : mul_lo;
  assign tail_tag   = dl_tag_reg[LAT-1];
  assign fifo_empty = (count_reg == '0);

`ifdef MUL32P_RETIRE_BYPASS_EN
  assign bypass = rst_n & tail_valid & fifo_empty & io.out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = tail_valid & ~bypass;
  assign pop  = rst_n & ~fifo_empty & io.out_ready;

  always_comb begin
    io.out_valid = 1'b0;
    io.out_data  = '0;
    io.out_tag   = '0;
    if (rst_n && !fifo_empty) begin
      io.out_valid = 1'b1;
      io.out_data  = mem_data[rd_ptr_reg];
      io.out_tag   = mem_tag[rd_ptr_reg];
    end else if (bypass) begin
      io.out_valid = 1'b1;
      io.out_data  = tail_data;
      io.out_tag   = tail_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= tail_data;
      mem_tag[wr_ptr_reg]  <= tail_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The tail leaves the line whether it was written or bypassed.
      case ({accept, tail_valid})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && count_reg == CW'(DEPTH)));
endmodule

// File: tb/tb_mul32p_retire.sv
// Self-checking bench for mul32p_retire with a behavioural mul32p pipeline and
// a scoreboard queue of expected results.
module tb_mul32p_retire;
  // Short latency so that the credit window allows issuing every cycle.
  localparam int LAT   = 2;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
`ifdef MUL32P_RETIRE_BYPASS_EN
  localparam int EXP_LAT = LAT;
`else
  localparam int EXP_LAT = LAT + 1;
`endif

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mul_mode;
  logic [31:0] mul_lo, mul_hi;
  logic [31:0] op_a, op_b;
  logic [63:0] pipe [LAT];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sbq[$];
  logic [31:0] cur_exp;
  bit          cur_lat;
  int          n_acc;

  mul32p_retire_if #(.TAG_W(TAG_W)) bus ();

  mul32p_retire #(.LAT(LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus),
    .mul_mode (mul_mode),
    .mul_lo   (mul_lo),
    .mul_hi   (mul_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mul32p: free-running pipeline, product of the mode driven at issue.
  function automatic logic [63:0] mul_model(input logic [1:0] mode, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = (mode == 2'b01 || mode == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    ye = (mode == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mul_model(mul_mode, op_a, op_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_lo = pipe[LAT-1][31:0];
  assign mul_hi = pipe[LAT-1][63:32];

  // Architectural result of a RISC-V M multiply.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, zx, sy, zy, p;
    sx = {{32{x[31]}}, x};
    zx = {32'b0, x};
    sy = {{32{y[31]}}, y};
    zy = {32'b0, y};
    case (op)
      2'b00:   begin p = zx * zy; return p[31:0];  end
      2'b01:   begin p = sx * sy; return p[63:32]; end
      2'b10:   begin p = sx * zy; return p[63:32]; end
      default: begin p = zx * zy; return p[63:32]; end
    endcase
  endfunction

  function automatic logic [1:0] mode_of(input logic [1:0] op);
    case (op)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard push on every accept; pop/compare on every consumed result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.issue_valid && bus.issue_ready) begin
      e.data = cur_exp;
      e.tag  = bus.issue_tag;
      e.acc  = cyc + 1;
      e.lat  = cur_lat;
      sbq.push_back(e);
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      $display("result tag=%0d data=%08h pop_edge=%0d", bus.out_tag, bus.out_data, cyc + 1);
      if (sbq.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_tag", bus.out_tag, e.tag);
        if (e.lat) chk("latency", cyc + 1 - e.acc, EXP_LAT);
      end
    end
  end

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sbq.size() == 0 && !bus.out_valid) done = 1;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp, input logic [1:0] exp_mode);
    @(posedge clk); #1;
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_tag   = tag;
    op_a            = x;
    op_b            = y;
    cur_exp         = exp;
    cur_lat         = 1'b1;
    @(negedge clk);
    chk("mul_mode", mul_mode, exp_mode);
    chk("issue_ready", bus.issue_ready, 1);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_op = 2'b00;
    bus.issue_tag = '0;
    bus.out_ready = 1'b1;
    op_a = 0;
    op_b = 0;
    cur_exp = 0;
    cur_lat = 0;

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_issue_ready", bus.issue_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_issue_ready", bus.issue_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // Directed products
    do_op(2'b00, 32'd292, 32'd6785, 5'd5, 32'd1981220, 2'b00);
    do_op(2'b01, -32'sd12345678, 32'd87654321, 5'd6, 32'hFFFC27C9, 2'b01);
    do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 2'b00);
    do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 2'b10);

    // Backpressure: issue continuously with the consumer stalled
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.issue_valid = 1'b1;
      bus.issue_op    = 2'b00;
      bus.issue_tag   = TAG_W'(n_acc);
      op_a            = 32'(n_acc + 10);
      op_b            = 32'd3;
      cur_exp         = 32'((n_acc + 10) * 3);
      cur_lat         = 1'b0;
      @(negedge clk);
      if (bus.issue_ready) n_acc++;
    end
    chk("bp_accepts", n_acc, DEPTH);
    chk("bp_ready_low", bus.issue_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_credit_same_cycle", bus.issue_ready, 0);
    @(negedge clk);
    chk("bp_credit_after_pop", bus.issue_ready, 1);
    drain();

    // Back-to-back issue with a free consumer
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      bus.issue_valid = 1'b1;
      bus.issue_op    = 2'(i % 4);
      bus.issue_tag   = TAG_W'(i + 16);
      op_a            = $urandom;
      op_b            = $urandom;
      cur_exp         = ref_res(bus.issue_op, op_a, op_b);
      cur_lat         = 1'b1;
      @(negedge clk);
      chk("b2b_ready", bus.issue_ready, 1);
      chk("b2b_mode", mul_mode, mode_of(bus.issue_op));
    end
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    drain();

    // Reset with three ops in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.issue_valid = 1'b1;
      bus.issue_op    = 2'b00;
      bus.issue_tag   = TAG_W'(i + 1);
      op_a            = 32'(i + 100);
      op_b            = 32'd7;
      cur_exp         = 32'((i + 100) * 7);
      cur_lat         = 1'b0;
    end
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_issue_ready", bus.issue_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", bus.out_valid, 0);
    end
    do_op(2'b00, 32'd1234, 32'd5678, 5'd9, 32'd7006652, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul32p_retire.md
Name: mul32p_retire

Overview:
- Retire/writeback stage directly downstream of the 8-stage pipelined Dadda multiplier `mul32p`.
- Accepts RISC-V M-extension multiply issues (MUL/MULH/MULHSU/MULHU) with a destination tag, and drives `mul32p` mode.
- Carries valid/op/tag through a delay line matched to multiplier latency, selects lo or hi word, and buffers results in a small FIFO with valid/ready output.
- `mul32p` has no stall, so a credit scheme guarantees the FIFO never overflows.

Parameters:
- LAT, 8: `mul32p` pipeline latency in cycles; must be ≥1.
- TAG_W, 5: tag width.
- DEPTH, 4: result FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- issue_valid  in  1  issue request; operands a/b go to `mul32p` in the same cycle
- issue_ready  out  1  issue may be accepted this cycle
- issue_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- issue_tag  in  TAG_W  destination tag
- mul_mode  out  2  to `mul32p` mode: MUL→00, MULH→01, MULHSU→10, MULHU→00
- mul_lo  in  32  `mul32p` lo
- mul_hi  in  32  `mul32p` hi
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  32  selected result word
- out_tag  out  TAG_W  tag of result

Behaviour:
- Accept = issue_valid & issue_ready at a rising edge.
- mul_mode is combinational from issue_op, regardless of issue_valid.
- Delay line: LAT stages of {valid, sel_hi, tag}.
  - Stage 0 loads {accept, issue_op!=00, issue_tag} each edge; stages shift every edge unconditionally.
  - An issue accepted at edge N sits in stage LAT-1 after edge N+LAT-1, aligned with its product on mul_lo/mul_hi.
- FIFO write at edge N+LAT when the tail is valid. Data is mul_lo if sel_hi=0, else mul_hi; the tag is written with it.
- FIFO read: out_valid = count≠0; out_data/out_tag = head entry. Pop on out_valid & out_ready.
- Issue-to-out_valid latency: LAT+1 cycles with an empty FIFO.
- Credit:
  - inflight = registered count of valid delay-line entries: +1 on accept, −1 on tail write, unchanged on both together.
  - issue_ready = (inflight + count) < DEPTH, using registered values only; a same-cycle pop does not add credit.
- FIFO: push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH. Push while full cannot occur; an assertion flags it in simulation.
- Empty FIFO: out_valid=0 and out_data/out_tag are forced to 0.
- Reset (rst_n=0 at edge):
  - Clears all delay-line valids, inflight, count and pointers.
  - Outputs: out_valid=0, out_data=0, out_tag=0, issue_ready=0 during the reset cycle, then 1.
  - Reset mid-operation discards in-flight ops; later `mul32p` outputs are ignored because their valids are cleared.
- issue_ready=0: issue_valid has no effect. Operand stability is the issuer's responsibility.

Optional Feature:
- Macro: MUL32P_RETIRE_BYPASS_EN.
- Defined:
  - When the tail is valid, count=0 and out_ready=1, the tail result drives out_valid/out_data/out_tag combinationally and is not written to the FIFO.
  - Latency becomes LAT cycles.
  - The inflight decrement still occurs.
  - If out_ready=0, normal FIFO write.
- Undefined: all results pass through the FIFO; latency LAT+1.

Test Plan:
- MUL, a=292, b=6785, out_ready=1 → out_valid exactly LAT+1 cycles after accept (LAT with bypass), out_data=1981220, correct tag, mul_mode=00.
- MULH, a=-12345678, b=87654321 → mul_mode=01, out_data=0xFFFC27C9 (-251959).
- MULHU 0xFFFFFFFF×0xFFFFFFFF → out_data=0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF → mul_mode=10, out_data=0xFFFFFFFF.
- Backpressure:
  - Hold out_ready=0 and assert issue_valid continuously → exactly DEPTH=4 accepts, then issue_ready=0.
  - After all results land, count=4 with no overflow.
  - Release out_ready → 4 results in issue order with tags 0..3; issue_ready returns 1 the cycle after the first pop.
- Back-to-back: issue every cycle with out_ready=1 → one result per cycle and no bubbles after the fill latency.
- Reset: 3 ops in flight, pulse rst_n low for 1 cycle → out_valid stays 0 for the following 2·LAT cycles, and a new issue then completes normally.
